// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// fifo_stream_reader : pulls beats from a 1-cycle-latency synchronous FIFO
// into a 2-entry skid buffer and presents them as a valid/ready stream.
// Option macro: FIFO_STREAM_READER_BEAT_CNT_EN adds the beat_cnt output.
// Revision: 1.0
// ============================================================================
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  output logic [15:0]           beat_cnt,
`endif
  output logic                  idle
);

  localparam logic [2:0] C_BUF_DEPTH = 3'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] skid_q [2];
  logic [DATA_WIDTH-1:0] skid_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  pop;
  logic [2:0]            level_after_pop;

  // Reads are throttled on the level left after this cycle's pop, so a
  // ready sink lets a new read overlap the beat leaving the buffer.
  always_comb begin
    m_valid         = !rst && (occ_q != 2'd0);
    m_data          = rst ? '0 : skid_q[rd_ptr_q];
    pop             = m_valid && m_ready;
    level_after_pop = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en      = !rst && !fifo_empty && (level_after_pop < C_BUF_DEPTH);
    idle            = rst ? fifo_empty
                          : ((occ_q == 2'd0) && !inflight_q && fifo_empty);
  end

  always_comb begin
    skid_d     = skid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = fifo_rd_en;
    occ_d      = level_after_pop[1:0];
    if (inflight_q) begin
      skid_d[wr_ptr_q] = fifo_rdata;
      wr_ptr_d         = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q + {15'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= 16'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// tb_fifo_stream_reader : directed bench with a behavioural FIFO and an
// in-order scoreboard for the fifo_stream_reader stream output.
// Revision: 1.0
// ============================================================================
module tb_fifo_stream_reader;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata = 8'hEE;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          idle;
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
  logic [15:0]   beat_cnt;
  logic [15:0]   bc_model = 16'd0;
  logic          rst_seen = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_mem [$];
  logic [7:0] exp_q [$];
  int push_cnt  = 0;
  int rd_count  = 0;
  int pops      = 0;
  int discarded = 0;
  logic underflow = 1'b0;
  int outstanding;
  int rd_base;
  int ndrop;
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev  = 8'h00;

  always #5 clk = ~clk;

  assign fifo_empty = (push_cnt == rd_count);

  fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
    .beat_cnt   (beat_cnt),
`endif
    .idle       (idle)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem.push_back(d);
    exp_q.push_back(d);
    push_cnt++;
  endtask

  task automatic drain(input int max_cyc, input string tag);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(idle && exp_q.size() == 0), 1);
  endtask

  // Behavioural FIFO: registered read data, garbage on non-read cycles.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_mem.size() == 0) begin
        underflow <= 1'b1;
      end else begin
        fifo_rdata <= fifo_mem.pop_front();
        rd_count   <= rd_count + 1;
      end
    end else begin
      fifo_rdata <= 8'($urandom);
    end
  end

  // Stream monitor: scoreboard, stability, occupancy bound, read legality.
  always @(negedge clk) begin
    outstanding = rd_count - pops - discarded;
    check("occ_inflight_le2", 32'(outstanding <= 2), 1);
    if (fifo_rd_en) check("rd_en_while_empty", 32'(fifo_empty), 0);
    if (stall_prev) begin
      check("stall_valid", 32'(m_valid), 1);
      check("stall_data", 32'(m_data), 32'(data_prev));
    end
    if (!rst && m_valid && m_ready) begin
      check("scoreboard_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
      pops++;
    end
    stall_prev = !rst && m_valid && !m_ready;
    data_prev  = m_data;
`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
    if (rst_seen) check("beat_cnt_track", 32'(beat_cnt), 32'(bc_model));
    if (rst) begin
      bc_model = 16'd0;
      rst_seen = 1'b1;
    end else if (m_valid && m_ready) begin
      bc_model = bc_model + 16'd1;
    end
`endif
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_idle", 32'(idle), 1);

    @(posedge clk); #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("idle_after_rst", 32'(idle), 1);
    check("valid_after_rst", 32'(m_valid), 0);

    // Three beats: read latency and back-to-back delivery.
    @(posedge clk); #1;
    push(8'h11); push(8'h22); push(8'h33);
    @(negedge clk);
    check("t1_rd_en_first", 32'(fifo_rd_en), 1);
    check("t1_valid_n0", 32'(m_valid), 0);
    @(negedge clk);
    check("t1_valid_n1", 32'(m_valid), 0);
    @(negedge clk);
    check("t1_valid_b0", 32'(m_valid), 1);
    check("t1_data_b0", 32'(m_data), 'h11);
    @(negedge clk);
    check("t1_data_b1", 32'(m_data), 'h22);
    @(negedge clk);
    check("t1_data_b2", 32'(m_data), 'h33);
    @(negedge clk);
    check("t1_valid_end", 32'(m_valid), 0);
    check("t1_idle_end", 32'(idle), 1);

    // Sixteen preloaded beats, sink always ready: no bubbles.
    @(posedge clk); #1;
    rd_base = rd_count;
    for (int i = 0; i < 16; i++) push(8'(i));
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("t2_no_bubble", 32'(m_valid), 1);
    end
    @(negedge clk);
    check("t2_valid_end", 32'(m_valid), 0);
    check("t2_reads", 32'(rd_count - rd_base), 16);
    check("t2_underflow", 32'(underflow), 0);

    // Sink stall: exactly two reads, head beat held stable.
    @(posedge clk); #1;
    m_ready = 1'b0;
    rd_base = rd_count;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    repeat (10) @(negedge clk);
    check("t3_reads", 32'(rd_count - rd_base), 2);
    check("t3_valid", 32'(m_valid), 1);
    check("t3_data", 32'(m_data), 'hA0);
    check("t3_fifo_left", 32'(fifo_mem.size()), 3);
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain(30, "t3_drained");

    // Toggling ready: every beat exactly once, in order.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    for (int i = 0; i < 40 && !(idle && exp_q.size() == 0); i++) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    check("t4_drained", 32'(idle && exp_q.size() == 0), 1);

    // Reset with one buffered and one in-flight beat.
    @(posedge clk); #1;
    m_ready = 1'b0;
    push(8'hC0); push(8'hC1); push(8'hC2);
    repeat (10) @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b1;
    ndrop = rd_count - pops - discarded;
    check("t5_discard_cnt", 32'(ndrop), 2);
    for (int i = 0; i < ndrop; i++) void'(exp_q.pop_front());
    discarded += ndrop;
    @(negedge clk);
    check("t5_rst_valid", 32'(m_valid), 0);
    check("t5_rst_data", 32'(m_data), 0);
    check("t5_rst_rd_en", 32'(fifo_rd_en), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_post_valid", 32'(m_valid), 0);
    check("t5_post_idle", 32'(idle), 1);
    @(posedge clk); #1;
    push(8'h5A);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("t5_5a_valid", 32'(m_valid), 1);
    check("t5_5a_data", 32'(m_data), 'h5A);
    drain(10, "t5_drained");

`ifdef FIFO_STREAM_READER_BEAT_CNT_EN
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) push(8'(i * 3));
    drain(40, "bc_drain20");
    check("bc_20", 32'(beat_cnt), 20);
    @(posedge clk); #1;
    for (int i = 0; i < 65515; i++) push(8'(i));
    drain(66000, "bc_drain_ffff");
    check("bc_ffff", 32'(beat_cnt), 'hFFFF);
    @(posedge clk); #1;
    push(8'h77);
    drain(10, "bc_drain_wrap");
    check("bc_wrap", 32'(beat_cnt), 0);
`endif

    check("final_underflow", 32'(underflow), 0);
    check("final_scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
